// File: rtl/l1d_mshr_pkg.sv
// Shared types and helpers for the L1D miss-status holding register file.
// Optional counters in the top are enabled by defining MSHR_PERF_CNT_EN.
package l1d_mshr_pkg;

  localparam int MSHR_PADDR_W = 22;
  localparam int MSHR_TAG_W = 10;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    PEND_REQ  = 2'd1,
    WAIT_FILL = 2'd2,
    DRAIN     = 2'd3
  } mshr_state_e;

  typedef struct packed {
    logic [MSHR_PADDR_W-1:0] paddr;
    logic                    we;
    logic [63:0]             data;
    logic [MSHR_TAG_W-1:0]   tag;
  } mshr_target_t;

  function automatic logic [31:0] block_addr(
    input logic [31:0] paddr,
    input int unsigned off_bits
  );
    return paddr >> off_bits;
  endfunction

endpackage

// File: rtl/l1d_mshr_file_target_fifo.sv
// Per-entry FIFO of merged miss targets, replayed in arrival order.
// Synchronous clear empties it; asynchronous reset also empties it.
module mshr_target_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       clr_in,
  input  logic                       push_in,
  input  logic [W-1:0]               din_in,
  input  logic                       pop_in,
  output logic [W-1:0]               dout_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out,
  output logic                       full_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + PW'(1));
  endfunction

  assign empty_out = (cnt_q == '0);
  assign full_out  = (cnt_q == CW'(DEPTH));
  assign count_out = cnt_q;
  assign dout_out  = mem_q[rptr_q];
  assign do_push   = push_in && !full_out;
  assign do_pop    = pop_in && !empty_out;

  // Next pointers, count and storage for push/pop/clear.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_in) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = din_in;
        wptr_d = inc(wptr_q);
      end
      if (do_pop) begin
        rptr_d = inc(rptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/l1d_mshr_file.sv
// Miss-status holding register file: CAM by block, target merge, replay.
// Define MSHR_PERF_CNT_EN to add saturating primary/secondary/stall counters.
module l1d_mshr_file
  import l1d_mshr_pkg::*;
#(
  parameter int N_MSHR = 4,
  parameter int N_TARGETS = 4,
  parameter int B = 64,
  parameter int PADDR_BITS = 22,
  parameter int TAG_BITS = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  alloc_valid_in,
  output logic                  alloc_ready_out,
  input  logic [PADDR_BITS-1:0] alloc_paddr_in,
  input  logic                  alloc_we_in,
  input  logic [63:0]           alloc_data_in,
  input  logic [TAG_BITS-1:0]   alloc_tag_in,
  output logic                  lc_req_valid_out,
  input  logic                  lc_req_ready_in,
  output logic [PADDR_BITS-1:0] lc_req_addr_out,
  input  logic                  fill_valid_in,
  output logic                  fill_ready_out,
  input  logic [PADDR_BITS-1:0] fill_addr_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [PADDR_BITS-1:0] resp_paddr_out,
  output logic                  resp_we_out,
  output logic [63:0]           resp_data_out,
  output logic [TAG_BITS-1:0]   resp_tag_out,
  output logic                  resp_last_out,
  output logic                  full_out
`ifdef MSHR_PERF_CNT_EN
  ,
  output logic [31:0]           primary_cnt_out,
  output logic [31:0]           secondary_cnt_out,
  output logic [31:0]           stall_cnt_out
`endif
);

  localparam int OFFSET_BITS = $clog2(B);
  localparam int BW = PADDR_BITS - OFFSET_BITS;
  localparam int TW = PADDR_BITS + 1 + 64 + TAG_BITS;
  localparam int CW = $clog2(N_TARGETS + 1);
  localparam int IW = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

  mshr_state_e st_q [N_MSHR];
  mshr_state_e st_d [N_MSHR];
  logic [BW-1:0] blk_q [N_MSHR];
  logic [BW-1:0] blk_d [N_MSHR];

  logic [N_MSHR-1:0] f_push, f_pop, f_clr;
  logic [N_MSHR-1:0] f_empty, f_full;
  logic [CW-1:0]     f_cnt [N_MSHR];
  logic [TW-1:0]     f_head [N_MSHR];
  logic [TW-1:0]     tgt_in, head;

  logic [BW-1:0] a_blk, f_blk;
  logic          a_hit, free_any, fl_hit, dr_busy;
  logic [IW-1:0] a_idx, free_idx, fl_idx, dr_idx;
  logic          prim, sec, fill_fire;
  logic          rv, resp_fire, resp_last, lc_fire;
  logic          pick_ok;
  logic [IW-1:0] pick_idx;

  logic                  lc_valid_q, lc_valid_d;
  logic [IW-1:0]         lc_idx_q, lc_idx_d;
  logic [PADDR_BITS-1:0] lc_addr_q, lc_addr_d;

  assign a_blk  = BW'(block_addr(32'(alloc_paddr_in), OFFSET_BITS));
  assign f_blk  = BW'(block_addr(32'(fill_addr_in), OFFSET_BITS));
  assign tgt_in = {alloc_paddr_in, alloc_we_in, alloc_data_in, alloc_tag_in};

  // CAM lookups and lowest-index FREE / draining entry search.
  always_comb begin
    a_hit    = 1'b0;
    a_idx    = '0;
    fl_hit   = 1'b0;
    fl_idx   = '0;
    dr_busy  = 1'b0;
    dr_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < N_MSHR; i++) begin
      if (st_q[i] != FREE && blk_q[i] == a_blk) begin
        a_hit = 1'b1;
        a_idx = IW'(i);
      end
      if (st_q[i] == WAIT_FILL && blk_q[i] == f_blk) begin
        fl_hit = 1'b1;
        fl_idx = IW'(i);
      end
      if (st_q[i] == DRAIN) begin
        dr_busy = 1'b1;
        dr_idx  = IW'(i);
      end
    end
  end

  assign alloc_ready_out = a_hit
    ? (st_q[a_idx] != DRAIN && !f_full[a_idx])
    : free_any;
  assign prim = alloc_valid_in && alloc_ready_out && !a_hit;
  assign sec  = alloc_valid_in && alloc_ready_out && a_hit;

  assign fill_ready_out = !(fl_hit && dr_busy);
  assign fill_fire = fill_valid_in && fill_ready_out && fl_hit;

  assign head      = f_head[dr_idx];
  assign rv        = dr_busy && !f_empty[dr_idx];
  assign resp_fire = rv && resp_ready_in;
  assign resp_last = (f_cnt[dr_idx] == CW'(1));
  assign lc_fire   = lc_valid_q && lc_req_ready_in;

  assign resp_valid_out = rv;
  assign resp_paddr_out = rv ? head[TW-1 -: PADDR_BITS] : '0;
  assign resp_we_out    = rv && head[64 + TAG_BITS];
  assign resp_data_out  = rv ? head[TAG_BITS +: 64] : '0;
  assign resp_tag_out   = rv ? head[TAG_BITS-1:0] : '0;
  assign resp_last_out  = rv && resp_last;
  assign full_out       = !free_any;

  assign lc_req_valid_out = lc_valid_q;
  assign lc_req_addr_out  = lc_addr_q;

  // Entry transitions, FIFO controls and next lower-cache request.
  always_comb begin
    st_d   = st_q;
    blk_d  = blk_q;
    f_push = '0;
    f_pop  = '0;
    f_clr  = '0;
    if (prim) begin
      st_d[free_idx]   = PEND_REQ;
      blk_d[free_idx]  = a_blk;
      f_push[free_idx] = 1'b1;
    end
    if (sec) begin
      f_push[a_idx] = 1'b1;
    end
    if (lc_fire) begin
      st_d[lc_idx_q] = WAIT_FILL;
    end
    if (fill_fire) begin
      st_d[fl_idx] = DRAIN;
    end
    if (resp_fire) begin
      f_pop[dr_idx] = 1'b1;
      if (resp_last) begin
        st_d[dr_idx]  = FREE;
        f_clr[dr_idx] = 1'b1;
      end
    end
    pick_ok  = 1'b0;
    pick_idx = '0;
    if (!lc_valid_q || lc_req_ready_in) begin
      for (int i = N_MSHR - 1; i >= 0; i--) begin
        if ((st_q[i] == PEND_REQ &&
             !(lc_valid_q && lc_idx_q == IW'(i))) ||
            (prim && free_idx == IW'(i))) begin
          pick_ok  = 1'b1;
          pick_idx = IW'(i);
        end
      end
    end
    lc_valid_d = pick_ok || (lc_valid_q && !lc_req_ready_in);
    lc_idx_d   = pick_ok ? pick_idx : lc_idx_q;
    lc_addr_d  = pick_ok
      ? {blk_d[pick_idx], {OFFSET_BITS{1'b0}}}
      : lc_addr_q;
  end

  // Entry state, block tags and request register.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < N_MSHR; i++) begin
        st_q[i]  <= FREE;
        blk_q[i] <= '0;
      end
      lc_valid_q <= 1'b0;
      lc_idx_q   <= '0;
      lc_addr_q  <= '0;
    end else begin
      st_q       <= st_d;
      blk_q      <= blk_d;
      lc_valid_q <= lc_valid_d;
      lc_idx_q   <= lc_idx_d;
      lc_addr_q  <= lc_addr_d;
    end
  end

  for (genvar g = 0; g < N_MSHR; g++) begin : g_ent
    mshr_target_fifo #(
      .DEPTH(N_TARGETS),
      .W    (TW)
    ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_N_in),
      .clr_in   (f_clr[g]),
      .push_in  (f_push[g]),
      .din_in   (tgt_in),
      .pop_in   (f_pop[g]),
      .dout_out (f_head[g]),
      .count_out(f_cnt[g]),
      .empty_out(f_empty[g]),
      .full_out (f_full[g])
    );
  end

`ifdef MSHR_PERF_CNT_EN
  logic [31:0] prim_cnt_q, prim_cnt_d;
  logic [31:0] sec_cnt_q, sec_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign stall = alloc_valid_in && !alloc_ready_out;

  // Saturating event counters.
  always_comb begin
    prim_cnt_d  = prim_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (prim && prim_cnt_q != '1) prim_cnt_d = prim_cnt_q + 32'd1;
    if (sec && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + 32'd1;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      prim_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      prim_cnt_q  <= prim_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign primary_cnt_out   = prim_cnt_q;
  assign secondary_cnt_out = sec_cnt_q;
  assign stall_cnt_out     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_l1d_mshr_file.sv
// Bench for l1d_mshr_file: directed scenarios then random traffic,
// every cycle checked against a queue-level model of the MSHR entries.
module tb_l1d_mshr_file;
  import l1d_mshr_pkg::*;

  localparam int N = 4;
  localparam int T = 4;
  localparam int S_FREE = 0;
  localparam int S_PEND = 1;
  localparam int S_WAIT = 2;
  localparam int S_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_v, a_we, f_v, lc_rdy, r_rdy;
  logic [21:0] a_pa, f_pa;
  logic [63:0] a_d;
  logic [9:0]  a_tag;

  logic        alloc_ready_out, lc_req_valid_out, fill_ready_out;
  logic [21:0] lc_req_addr_out, resp_paddr_out;
  logic        resp_valid_out, resp_we_out, resp_last_out, full_out;
  logic [63:0] resp_data_out;
  logic [9:0]  resp_tag_out;

  l1d_mshr_file dut (
    .clk_in          (clk),
    .rst_N_in        (rst_n),
    .alloc_valid_in  (a_v),
    .alloc_ready_out (alloc_ready_out),
    .alloc_paddr_in  (a_pa),
    .alloc_we_in     (a_we),
    .alloc_data_in   (a_d),
    .alloc_tag_in    (a_tag),
    .lc_req_valid_out(lc_req_valid_out),
    .lc_req_ready_in (lc_rdy),
    .lc_req_addr_out (lc_req_addr_out),
    .fill_valid_in   (f_v),
    .fill_ready_out  (fill_ready_out),
    .fill_addr_in    (f_pa),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (r_rdy),
    .resp_paddr_out  (resp_paddr_out),
    .resp_we_out     (resp_we_out),
    .resp_data_out   (resp_data_out),
    .resp_tag_out    (resp_tag_out),
    .resp_last_out   (resp_last_out),
    .full_out        (full_out)
  );

  int checks = 0;
  int errors = 0;

  int           m_st [N];
  logic [15:0]  m_blk [N];
  mshr_target_t m_t [N][T];
  int           m_n [N];

  int  lc_cnt = 0;
  int  resp_cnt = 0;
  bit  acc, facc;
  logic [9:0]  rtags [$];
  bit          rlast [$];
  bit          rwe [$];
  logic [63:0] rdata [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = S_FREE;
      m_n[i] = 0;
      m_blk[i] = '0;
    end
  endtask

  function automatic int mhit(input logic [15:0] b);
    for (int i = 0; i < N; i++)
      if (m_st[i] != S_FREE && m_blk[i] == b) return i;
    return -1;
  endfunction

  function automatic int mfree();
    for (int i = 0; i < N; i++)
      if (m_st[i] == S_FREE) return i;
    return -1;
  endfunction

  function automatic int mwait(input logic [15:0] b);
    for (int i = 0; i < N; i++)
      if (m_st[i] == S_WAIT && m_blk[i] == b) return i;
    return -1;
  endfunction

  function automatic int mdrain();
    for (int i = 0; i < N; i++)
      if (m_st[i] == S_DRAIN) return i;
    return -1;
  endfunction

  function automatic bit mall_free();
    for (int i = 0; i < N; i++)
      if (m_st[i] != S_FREE) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: inputs already set at the falling edge.
  task automatic step();
    int h, f, fh, d, k;
    bit pr, frdy;
    logic [15:0] ab, fb;
    mshr_target_t t;
    #1;
    ab = a_pa[21:6];
    fb = f_pa[21:6];
    h = mhit(ab);
    f = mfree();
    fh = mwait(fb);
    d = mdrain();
    pr = (h >= 0) ? (m_st[h] != S_DRAIN && m_n[h] < T) : (f >= 0);
    frdy = !(fh >= 0 && d >= 0);
    chk("alloc_ready", 64'(alloc_ready_out), 64'(pr));
    chk("full", 64'(full_out), 64'(f < 0));
    chk("fill_ready", 64'(fill_ready_out), 64'(frdy));
    chk("resp_valid", 64'(resp_valid_out), 64'(d >= 0));
    if (d >= 0) begin
      t = m_t[d][0];
      chk("resp_paddr", 64'(resp_paddr_out), 64'(t.paddr));
      chk("resp_we", 64'(resp_we_out), 64'(t.we));
      chk("resp_data", resp_data_out, t.data);
      chk("resp_tag", 64'(resp_tag_out), 64'(t.tag));
      chk("resp_last", 64'(resp_last_out), 64'(m_n[d] == 1));
    end
    k = -1;
    if (lc_req_valid_out) begin
      for (int i = 0; i < N; i++)
        if (m_st[i] == S_PEND && {m_blk[i], 6'h0} == lc_req_addr_out)
          k = i;
      chk("lc_req_addr", 64'(k >= 0), 64'd1);
    end
    acc = a_v && pr;
    facc = f_v && frdy;
    if (acc) begin
      t.paddr = a_pa;
      t.we = a_we;
      t.data = a_d;
      t.tag = a_tag;
      if (h >= 0) begin
        m_t[h][m_n[h]] = t;
        m_n[h]++;
      end else begin
        m_st[f] = S_PEND;
        m_blk[f] = ab;
        m_t[f][0] = t;
        m_n[f] = 1;
      end
    end
    if (lc_req_valid_out && lc_rdy) begin
      lc_cnt++;
      if (k >= 0) m_st[k] = S_WAIT;
    end
    if (facc && fh >= 0) m_st[fh] = S_DRAIN;
    if (d >= 0 && r_rdy) begin
      rtags.push_back(resp_tag_out);
      rlast.push_back(resp_last_out);
      rwe.push_back(resp_we_out);
      rdata.push_back(resp_data_out);
      for (int j = 0; j < m_n[d] - 1; j++) m_t[d][j] = m_t[d][j + 1];
      m_n[d]--;
      if (m_n[d] == 0) m_st[d] = S_FREE;
      resp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_v = 1'b0;
    f_v = 1'b0;
    repeat (n) step();
  endtask

  task automatic alloc(input logic [21:0] pa, input logic we,
                       input logic [63:0] d, input logic [9:0] tag);
    a_v = 1'b1;
    a_pa = pa;
    a_we = we;
    a_d = d;
    a_tag = tag;
    step();
    a_v = 1'b0;
  endtask

  task automatic fill_drain(input logic [21:0] pa);
    bit done = 1'b0;
    f_v = 1'b1;
    f_pa = pa;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (facc) done = 1'b1;
    end
    f_v = 1'b0;
    chk("fill_accept", 64'(done), 64'd1);
    idle(8);
  endtask

  initial begin
    int l0, r0;
    bit done;
    rst_n = 1'b0;
    a_v = 0; a_we = 0; a_pa = '0; a_d = '0; a_tag = '0;
    f_v = 0; f_pa = '0; lc_rdy = 1'b1; r_rdy = 1'b1;
    mreset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready_out), 64'd1);
    chk("rst_fill_ready", 64'(fill_ready_out), 64'd1);
    chk("rst_lc_valid", 64'(lc_req_valid_out), 64'd0);
    chk("rst_lc_addr", 64'(lc_req_addr_out), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_out), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag_out), 64'd0);
    chk("rst_resp_last", 64'(resp_last_out), 64'd0);
    chk("rst_full", 64'(full_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single load miss
    l0 = lc_cnt;
    r0 = resp_cnt;
    alloc(22'h01040, 1'b0, 64'd0, 10'd5);
    chk("t1_lc_latency", 64'(lc_req_valid_out), 64'd1);
    chk("t1_lc_addr", 64'(lc_req_addr_out), 64'h01040);
    idle(3);
    chk("t1_lc_once", 64'(lc_cnt - l0), 64'd1);
    f_v = 1'b1;
    f_pa = 22'h01040;
    step();
    f_v = 1'b0;
    chk("t1_resp_latency", 64'(resp_valid_out), 64'd1);
    chk("t1_tag", 64'(resp_tag_out), 64'd5);
    chk("t1_last", 64'(resp_last_out), 64'd1);
    idle(3);
    chk("t1_resp_count", 64'(resp_cnt - r0), 64'd1);

    // four merged targets
    l0 = lc_cnt;
    alloc(22'h02000, 1'b0, 64'd0, 10'd1);
    alloc(22'h02008, 1'b0, 64'd0, 10'd2);
    alloc(22'h02010, 1'b0, 64'd0, 10'd3);
    alloc(22'h02018, 1'b1, 64'hDEAD, 10'd4);
    idle(3);
    chk("t2_lc_once", 64'(lc_cnt - l0), 64'd1);
    rtags.delete(); rlast.delete(); rwe.delete(); rdata.delete();
    fill_drain(22'h02000);
    chk("t2_resp_count", 64'(rtags.size()), 64'd4);
    if (rtags.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_tag_order", 64'(rtags[i]), 64'(i + 1));
        chk("t2_last_flag", 64'(rlast[i]), 64'(i == 3));
      end
      chk("t2_store_we", 64'(rwe[3]), 64'd1);
      chk("t2_store_data", rdata[3], 64'hDEAD);
    end

    // all entries busy
    alloc(22'h10000, 1'b0, 64'd0, 10'd20);
    alloc(22'h11000, 1'b0, 64'd0, 10'd21);
    alloc(22'h12000, 1'b0, 64'd0, 10'd22);
    alloc(22'h13000, 1'b0, 64'd0, 10'd23);
    chk("t3_full", 64'(full_out), 64'd1);
    a_v = 1'b1;
    a_pa = 22'h14000;
    a_tag = 10'd24;
    repeat (3) step();
    chk("t3_stalled", 64'(acc), 64'd0);
    f_v = 1'b1;
    f_pa = 22'h10000;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (facc) f_v = 1'b0;
      if (acc) done = 1'b1;
    end
    a_v = 1'b0;
    f_v = 1'b0;
    chk("t3_accept_after_drain", 64'(done), 64'd1);
    idle(3);
    fill_drain(22'h11000);
    fill_drain(22'h12000);
    fill_drain(22'h13000);
    fill_drain(22'h14000);

    // target list overflow
    l0 = lc_cnt;
    r0 = resp_cnt;
    for (int i = 0; i < 4; i++)
      alloc(22'h03000 + 22'(8 * i), 1'b0, 64'd0, 10'(10 + i));
    a_v = 1'b1;
    a_pa = 22'h03020;
    a_tag = 10'd14;
    step();
    chk("t4_stalled", 64'(acc), 64'd0);
    step();
    f_v = 1'b1;
    f_pa = 22'h03000;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (facc) f_v = 1'b0;
      if (acc) done = 1'b1;
    end
    a_v = 1'b0;
    f_v = 1'b0;
    chk("t4_accept_after_drain", 64'(done), 64'd1);
    chk("t4_drained_first", 64'(resp_cnt - r0), 64'd4);
    idle(3);
    chk("t4_new_primary", 64'(lc_cnt - l0), 64'd2);
    fill_drain(22'h03000);
    chk("t4_resp_total", 64'(resp_cnt - r0), 64'd5);

    // unmatched fill, fill blocked behind a drain
    r0 = resp_cnt;
    f_v = 1'b1;
    f_pa = 22'h3F000;
    step();
    f_v = 1'b0;
    chk("t5_nomatch_resp", 64'(resp_valid_out), 64'd0);
    chk("t5_nomatch_full", 64'(full_out), 64'd0);
    alloc(22'h05000, 1'b0, 64'd0, 10'd30);
    alloc(22'h06000, 1'b0, 64'd0, 10'd31);
    idle(3);
    f_v = 1'b1;
    f_pa = 22'h05000;
    step();
    r_rdy = 1'b0;
    f_pa = 22'h06000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_fill_blocked", 64'(fill_ready_out), 64'd0);
    end
    r_rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (facc) done = 1'b1;
    end
    f_v = 1'b0;
    chk("t5_fill_accepted", 64'(done), 64'd1);
    chk("t5_after_last", 64'(resp_cnt - r0), 64'd1);
    idle(8);
    chk("t5_resp_total", 64'(resp_cnt - r0), 64'd2);

    // reset while draining
    alloc(22'h07000, 1'b0, 64'd0, 10'd40);
    idle(3);
    f_v = 1'b1;
    f_pa = 22'h07000;
    step();
    f_v = 1'b0;
    r_rdy = 1'b0;
    idle(2);
    chk("t6_draining", 64'(resp_valid_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_resp_valid", 64'(resp_valid_out), 64'd0);
    chk("t6_rst_full", 64'(full_out), 64'd0);
    chk("t6_rst_alloc_ready", 64'(alloc_ready_out), 64'd1);
    chk("t6_rst_lc_valid", 64'(lc_req_valid_out), 64'd0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    r_rdy = 1'b1;
    alloc(22'h08000, 1'b0, 64'd0, 10'd41);
    chk("t6_realloc_lc", 64'(lc_req_valid_out), 64'd1);
    chk("t6_realloc_addr", 64'(lc_req_addr_out), 64'h08000);
    idle(3);
    fill_drain(22'h08000);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      a_v = 1'($urandom_range(0, 1));
      a_pa = {16'h0800 + 16'($urandom_range(0, 5)),
              3'($urandom_range(0, 7)), 3'b000};
      a_we = 1'($urandom_range(0, 1));
      a_d = {$urandom, $urandom};
      a_tag = 10'($urandom);
      f_v = ($urandom_range(0, 3) == 0);
      f_pa = {16'h0800 + 16'($urandom_range(0, 6)), 6'h00};
      lc_rdy = ($urandom_range(0, 2) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    a_v = 1'b0;
    lc_rdy = 1'b1;
    r_rdy = 1'b1;
    for (int c = 0; c < 400 && !mall_free(); c++) begin
      f_v = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == S_WAIT) begin
          f_v = 1'b1;
          f_pa = {m_blk[i], 6'h00};
        end
      end
      step();
    end
    f_v = 1'b0;
    chk("final_all_free", 64'(mall_free()), 64'd1);
    idle(2);
    chk("final_full", 64'(full_out), 64'd0);
    chk("final_lc_idle", 64'(lc_req_valid_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
